// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t   : controller state encoding (IDLE / SHIFT / DONE)
//   DEF_WIDTH : default operand width used when no parameter is given
package serial_arith_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: x - y.
//   x  : minuend bit
//   y  : subtrahend bit
//   d  : difference bit (x ^ y)
//   bo : borrow out (~x & y)
// Two instances plus an OR form a full-subtract stage.
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);

   assign d  = x ^ y;
   assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : request, sampled only in IDLE
//   a, b             : operands, captured when start is accepted
//   busy             : high while the WIDTH bits are being processed
//   done             : one-cycle pulse when diff/borrow_out/ovf are new
//   diff             : a - b modulo 2^WIDTH, held until the next completion
//   borrow_out       : unsigned borrow (a < b)
//   ovf              : signed two's-complement overflow of a - b
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state, state_next;
   logic [WIDTH-1:0]   sa, sb, res;
   logic               bor;
   logic               a_msb, b_msb;
   logic [CNT_W-1:0]   cnt;
   logic               last_bit;

   // Full-subtract stage: (sa[0] - sb[0]) then minus the incoming borrow.
   logic d0, bo0, d_bit, bo1, bor_next;

   half_subtractor u_hs_op (
      .x  (sa[0]),
      .y  (sb[0]),
      .d  (d0),
      .bo (bo0)
   );

   half_subtractor u_hs_bor (
      .x  (d0),
      .y  (bor),
      .d  (d_bit),
      .bo (bo1)
   );

   assign bor_next = bo0 | bo1;
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_next = ST_SHIFT;
         ST_SHIFT: begin
            busy = 1'b1;
            if (last_bit) state_next = ST_DONE;
         end
         ST_DONE:  begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the shift registers are plain flops (not a memory), so they are
      // cleared on reset along with the visible outputs.
      if (!rst_n) begin
         sa         <= '0;
         sb         <= '0;
         res        <= '0;
         bor        <= 1'b0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
                  bor   <= 1'b0;
                  cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               res <= {d_bit, res[WIDTH-1:1]};
               bor <= bor_next;
               cnt <= cnt + CNT_W'(1);
               // Results are published only on the edge that enters DONE,
               // so they stay stable throughout the following operation.
               if (last_bit) begin
                  diff       <= {d_bit, res[WIDTH-1:1]};
                  borrow_out <= bor_next;
                  ovf        <= (a_msb != b_msb) && (d_bit != a_msb);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4). Expected results come
// from an arithmetic reference model: modular difference, unsigned compare
// for the borrow, and signed range test for overflow.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done;
   logic [W-1:0] diff;
   logic         borrow_out, ovf;

   int errors = 0;
   int checks = 0;

   // Last published result; outputs must hold it while an operation runs.
   logic [W-1:0] prev_diff = '0;
   logic         prev_bor  = 1'b0;
   logic         prev_ovf  = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   function automatic int to_signed(input logic [W-1:0] v);
      int r;
      r = int'(v);
      if (v[W-1]) r = r - (1 << W);
      return r;
   endfunction

   task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] d, output logic bo, output logic ov);
      int sd;
      d  = W'((int'(x) - int'(y) + (1 << W)) % (1 << W));
      bo = (int'(x) < int'(y));
      sd = to_signed(x) - to_signed(y);
      ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
   endtask

   // Launch one operation and follow it to its done pulse. inject_at > 0
   // drives a second start (a=1, b=1) at that cycle after acceptance.
   // quiet_after checks that nothing further happens afterwards.
   task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input int inject_at, input bit quiet_after,
                         input string name);
      logic [W-1:0] ed;
      logic         eb, eo;
      int           cyc, busy_cnt;
      bit           got;
      model(a_i, b_i, ed, eb, eo);
      @(negedge clk);
      a = a_i; b = b_i; start = 1'b1;
      cyc = 0; busy_cnt = 0; got = 1'b0;
      while (!got && cyc < 4 * W + 8) begin
         @(negedge clk);
         cyc++;
         if (cyc == inject_at) begin
            start = 1'b1; a = W'(1); b = W'(1);
         end else begin
            start = 1'b0; a = W'($urandom); b = W'($urandom);
         end
         if (done) got = 1'b1;
         else begin
            if (busy) busy_cnt++;
            checks++;
            if ({diff, borrow_out, ovf} !== {prev_diff, prev_bor, prev_ovf}) begin
               errors++;
               $display("FAIL %s hold cyc%0d: got %h/%b/%b want %h/%b/%b", name, cyc,
                        diff, borrow_out, ovf, prev_diff, prev_bor, prev_ovf);
            end
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
      end
      checks++;
      if (cyc !== W + 1) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, cyc, W + 1);
      end
      checks++;
      if (busy_cnt !== W || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy: cycles %0d busy_at_done %b want %0d and 0", name, busy_cnt, busy, W);
      end
      checks++;
      if (diff !== ed) begin
         errors++;
         $display("FAIL %s diff: got %b want %b", name, diff, ed);
      end
      checks++;
      if (borrow_out !== eb) begin
         errors++;
         $display("FAIL %s borrow_out: got %b want %b", name, borrow_out, eb);
      end
      checks++;
      if (ovf !== eo) begin
         errors++;
         $display("FAIL %s ovf: got %b want %b", name, ovf, eo);
      end
      prev_diff = ed; prev_bor = eb; prev_ovf = eo;
      if (quiet_after) begin
         for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
               errors++;
               $display("FAIL %s ignored_start: done %b busy %b want 0 0", name, done, busy);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, diff, borrow_out, ovf} !== '0) begin
         errors++;
         $display("FAIL reset: busy %b done %b diff %h bor %b ovf %b want all 0",
                  busy, done, diff, borrow_out, ovf);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_op(4'd3, 4'd3, 0, 1'b0, "3-3");
      run_op(4'd0, 4'd1, 0, 1'b0, "0-1");
      run_op(4'd5, 4'd9, 0, 1'b0, "5-9");
      run_op(4'd8, 4'd1, 0, 1'b0, "8-1");
   endtask

   task automatic test_corners();
      run_op(4'd0,  4'd0,  0, 1'b0, "0-0");
      run_op(4'd15, 4'd15, 0, 1'b0, "15-15");
      run_op(4'd0,  4'd15, 0, 1'b0, "0-15");
      run_op(4'd7,  4'd8,  0, 1'b0, "7-8");
      run_op(4'd8,  4'd7,  0, 1'b0, "8-7");
   endtask

   task automatic test_start_while_busy();
      run_op(4'd9, 4'd5, 2, 1'b1, "busy_start");
   endtask

   task automatic test_start_in_done();
      run_op(4'd12, 4'd3, W + 1, 1'b1, "done_start");
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      a = 4'd7; b = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort pre: busy %b want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, diff, borrow_out, ovf} !== '0) begin
         errors++;
         $display("FAIL abort reset: busy %b done %b diff %h bor %b ovf %b want all 0",
                  busy, done, diff, borrow_out, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      prev_diff = '0; prev_bor = 1'b0; prev_ovf = 1'b0;
      for (int i = 0; i < W + 3; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || diff !== '0) begin
            errors++;
            $display("FAIL abort quiet: done %b busy %b diff %h want 0 0 0", done, busy, diff);
         end
      end
      run_op(4'd7, 4'd2, 0, 1'b0, "after_abort");
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         run_op(W'($urandom), W'($urandom), 0, 1'b0, "random");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_while_busy();
      test_reset_abort();
      test_corners();
      test_start_in_done();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial W-bit subtractor computing diff = a - b, one bit per clock, LSB first, with a start/busy/done handshake. It is the subtracting counterpart of the team's ripple adder on the Nexys2 board. It trades the adder's parallel ripple chain for a single full-subtract stage plus shift registers. It sits between the switch/button input logic and the 7-segment/LED display logic.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..16)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when not busy
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when the result is valid
diff  output  WIDTH  a - b modulo 2^WIDTH; held until next accepted start completes
borrow_out  output  1  unsigned borrow (1 when a < b unsigned)
ovf  output  1  signed two's-complement overflow of a - b

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, diff=0, borrow_out=0, ovf=0; internal shift registers, bit counter and borrow register cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: when start=1, latch a into sa and b into sb, clear the borrow register and bit counter, then go to SHIFT. busy=1 from the next cycle. start=0 stays in IDLE.
- SHIFT, one bit per cycle:
  - d = sa[0] ^ sb[0] ^ bor
  - bor_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor)
  - d is shifted into the MSB of the result shift register; sa and sb shift right.
  - Counter increments; after WIDTH bits, go to DONE.
- DONE, exactly one cycle:
  - done=1, busy=0.
  - diff = result register.
  - borrow_out = final bor.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the latched operand MSBs.
  - Next state is IDLE.
- Latency: start accepted at edge 0 → done high during cycle WIDTH+1 (5 cycles for WIDTH=4). Throughput is one operation per WIDTH+2 cycles.
- diff, borrow_out and ovf update only when entering DONE. They are stable at all other times, including throughout the next operation.
- start while busy (SHIFT) is ignored; no queueing.
- start during the DONE cycle is ignored; the bench must reassert start in IDLE.
- a and b may change freely after acceptance; only the latched copies are used.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values; no done pulse follows.
- The counter is sized $clog2(WIDTH+1) and never wraps within an operation.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
  - default width constant DEF_WIDTH=4
- One sub-module, half_subtractor (inputs x, y; outputs d = x^y, bo = ~x&y).
  - It is instantiated twice to form the per-bit full-subtract stage.
  - The two bo terms are ORed to give bor_next.

Test Plan:
- Reset, then start with a=3, b=3 → done pulses in cycle 5; diff=0, borrow_out=0, ovf=0; busy high for exactly 4 cycles.
- a=0, b=1 → diff=4'b1111, borrow_out=1, ovf=0.
- a=5, b=9 → diff=4'b1100, borrow_out=1, ovf=1.
- a=8, b=1 → diff=4'b0111, borrow_out=0, ovf=1.
- Start a=9, b=5; pulse start with a=1, b=1 in cycle 2 while busy → result is diff=4'b0100, borrow_out=0, ovf=1. The second request is ignored: no second done follows.
- Start a=7, b=2; drop rst_n for one cycle in cycle 3 → outputs immediately 0, no done pulse. A following start with a=7, b=2 gives diff=5, borrow_out=0, ovf=0.
